// File: rtl/register_file_if.sv
// Register-file port bundle: one write port driven by write-back and two
// read ports feeding the ALU operand muxes.
interface register_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  // No valid/ready pair: reg_write qualifies write_reg/write_data on the
  // rising clock edge. The read ports are unqualified: read_data follows
  // read_reg combinationally in the same cycle.
  logic                  reg_write;
  logic [ADDR_WIDTH-1:0] write_reg;
  logic [DATA_WIDTH-1:0] write_data;
  logic [ADDR_WIDTH-1:0] read_reg1;
  logic [DATA_WIDTH-1:0] read_data1;
  logic [ADDR_WIDTH-1:0] read_reg2;
  logic [DATA_WIDTH-1:0] read_data2;

  // The datapath side drives indices and write data.
  modport master (
    output reg_write, write_reg, write_data, read_reg1, read_reg2,
    input  read_data1, read_data2
  );

  // The register file itself.
  modport slave (
    input  reg_write, write_reg, write_data, read_reg1, read_reg2,
    output read_data1, read_data2
  );
endinterface

// File: rtl/register_file.sv
// General-purpose CPU register file: NUM_REGS x DATA_WIDTH, two
// combinational read ports, one synchronous write port. Register 0 is
// hardwired to zero. There is no write-to-read bypass: a read of the index
// being written returns the old value until the writing edge.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 2 ** ADDR_WIDTH
) (
  input logic            clk,
  input logic            rst,
  register_file_if.slave bus
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Asynchronous clear of every register; on the clock, write the addressed
  // register unless it is index 0. Reset wins over a coincident write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.reg_write && (bus.write_reg != '0)) begin
      regs[bus.write_reg] <= bus.write_data;
    end
  end

  // Read port 1: index 0 is forced to zero regardless of storage.
  always_comb begin
    bus.read_data1 = '0;
    if (bus.read_reg1 != '0) begin
      bus.read_data1 = regs[bus.read_reg1];
    end
  end

  // Read port 2: independent of port 1, same zero-register rule.
  always_comb begin
    bus.read_data2 = '0;
    if (bus.read_reg2 != '0) begin
      bus.read_data2 = regs[bus.read_reg2];
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed vectors with hand-computed expectations.
// The driver pushes expected read values into a queue and raises a sample
// strobe; a separate monitor pops and compares against the read ports.
module tb_register_file;

  localparam int W = 32;
  localparam int A = 5;

  logic clk;
  logic rst;
  logic sample;

  register_file_if #(.DATA_WIDTH(W), .ADDR_WIDTH(A)) bus ();

  register_file #(.DATA_WIDTH(W), .ADDR_WIDTH(A)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           num_checks;
  int           num_fails;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard / monitor ----------------
  task automatic compare(input string name, input logic [W-1:0] got,
                         input logic [W-1:0] want);
    num_checks++;
    if (got !== want) begin
      num_fails++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  initial begin
    logic [W-1:0] e1;
    logic [W-1:0] e2;
    string        nm;
    forever begin
      @(posedge sample);
      while (name_q.size() > 0) begin
        nm = name_q.pop_front();
        e1 = exp_q.pop_front();
        e2 = exp_q.pop_front();
        compare({nm, " port1"}, bus.read_data1, e1);
        compare({nm, " port2"}, bus.read_data2, e2);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Present both read indices, queue expectations, strobe the monitor.
  task automatic check_reads(input string name,
                             input logic [A-1:0] a1, input logic [W-1:0] e1,
                             input logic [A-1:0] a2, input logic [W-1:0] e2);
    bus.read_reg1 = a1;
    bus.read_reg2 = a2;
    name_q.push_back(name);
    exp_q.push_back(e1);
    exp_q.push_back(e2);
    #1 sample = 1'b1;
    #1 sample = 1'b0;
  endtask

  // One write cycle: drive at the falling edge, hold through the rising edge.
  task automatic do_write(input logic en, input logic [A-1:0] addr,
                          input logic [W-1:0] data);
    @(negedge clk);
    bus.reg_write  = en;
    bus.write_reg  = addr;
    bus.write_data = data;
    @(posedge clk);
    #1;
    bus.reg_write = 1'b0;
  endtask

  function automatic logic [W-1:0] sweep_val(input int i);
    sweep_val = (i == 0) ? '0 : W'(i * 4 + 1);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    num_checks     = 0;
    num_fails      = 0;
    sample         = 1'b0;
    rst            = 1'b1;
    bus.reg_write  = 1'b0;
    bus.write_reg  = '0;
    bus.write_data = '0;
    bus.read_reg1  = '0;
    bus.read_reg2  = '0;

    // Reset: reads are zero while held and after release.
    #2;
    check_reads("reset_held", 5'd11, 32'd0, 5'd0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check_reads("reset_released", 5'd11, 32'd0, 5'd0, 32'd0);

    // Basic write then read.
    do_write(1'b1, 5'd3, 32'd22);
    check_reads("write_r3", 5'd3, 32'd22, 5'd3, 32'd22);
    check_reads("unwritten", 5'd12, 32'd0, 5'd10, 32'd0);

    // Writes to register 0 are dropped.
    do_write(1'b1, 5'd0, 32'hDEADBEEF);
    check_reads("zero_reg", 5'd0, 32'd0, 5'd3, 32'd22);

    // Write disabled leaves state unchanged.
    do_write(1'b0, 5'd9, 32'd55);
    check_reads("write_disabled", 5'd9, 32'd0, 5'd3, 32'd22);

    // Fill every register, then sweep both ports in opposite directions.
    for (int i = 1; i < 32; i++) begin
      do_write(1'b1, A'(i), W'(i * 4 + 1));
    end
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      check_reads("sweep", A'(i), sweep_val(i), A'(31 - i), sweep_val(31 - i));
    end

    // Asynchronous reset in the middle of the low phase clears at once.
    @(negedge clk);
    #1 rst = 1'b1;
    check_reads("async_reset_now", 5'd31, 32'd0, 5'd7, 32'd0);
    // A write attempted across an edge while reset is held is lost.
    bus.reg_write  = 1'b1;
    bus.write_reg  = 5'd7;
    bus.write_data = 32'h1234_5678;
    @(posedge clk);
    #1 bus.reg_write = 1'b0;
    for (int i = 0; i < 32; i += 4) begin
      check_reads("after_reset", A'(i), 32'd0, A'(i + 3), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    check_reads("reset_wins", 5'd7, 32'd0, 5'd1, 32'd0);

    // Read during write, same index: old value before the edge, new after.
    do_write(1'b1, 5'd5, 32'd7);
    @(negedge clk);
    bus.reg_write  = 1'b1;
    bus.write_reg  = 5'd5;
    bus.write_data = 32'd99;
    check_reads("rdw_before_edge", 5'd5, 32'd7, 5'd5, 32'd7);
    @(posedge clk);
    #1 bus.reg_write = 1'b0;
    check_reads("rdw_after_edge", 5'd5, 32'd99, 5'd0, 32'd0);

    // Every queued expectation must have been consumed by the monitor.
    #2;
    num_checks++;
    if (exp_q.size() != 0) begin
      num_fails++;
      $display("FAIL queue_drained: got %0d entries left required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
